// File: rtl/cdc_upload_framer.sv
// cdc_upload_framer
// Wraps a handler response payload into the USB-CDC upload frame
//   AA 55 CMD LEN_H LEN_L PAYLOAD[LEN] CSUM
// and streams it one byte per transfer onto usb_upload_data/valid.
//
// Handshake (all interfaces): a byte moves on a clock edge where both valid
// and ready are high; the sender keeps valid and data stable until then, and
// the receiver may change ready freely. Here usb_upload_* is the sending side,
// payload_* is the receiving side.
//
// The output register refills in the same cycle its byte transfers. FSM
// states name the byte held in the output register for the header bytes.
// PAYLOAD is entered when LEN_L is loaded, so the first payload byte can be
// accepted while LEN_L is still transferring. This gives one byte per cycle
// under constant ready. CSUM is loaded once the last payload byte has been
// loaded and the register can take a new byte.
//
// Checksum is the 8-bit sum of CMD, LEN_H, LEN_L and every payload byte that
// is actually sent (sync bytes are not included). If the handler stalls for
// STALL_LIMIT cycles, the remaining payload is sent as zero padding and the
// checksum still covers exactly the bytes on the wire.
module cdc_upload_framer #(
  parameter int MAX_LEN     = 256,
  parameter int STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [7:0]  frame_cmd,
  input  logic [15:0] frame_len,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic [7:0]  usb_upload_data,
  output logic        usb_upload_valid,
  input  logic        usb_upload_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error,
  output logic [2:0]  state_dbg
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [15:0]   MAX_LEN_W  = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC0   = 3'd1,
    S_SYNC1   = 3'd2,
    S_CMD     = 3'd3,
    S_LENH    = 3'd4,
    S_LENL    = 3'd5,
    S_PAYLOAD = 3'd6,
    S_CSUM    = 3'd7
  } state_t;

  state_t        state;
  logic [7:0]    cmd_q;
  logic [15:0]   len_q;
  logic [15:0]   remaining;
  logic [7:0]    csum;
  logic [SW-1:0] stall_cnt;
  logic          padding;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          done_q;
  logic          err_q;

  logic out_xfer;
  logic out_free;
  logic consume;

  // Output-register transfer / free-slot decode and payload acceptance
  always_comb begin
    out_xfer      = out_valid & usb_upload_ready;
    out_free      = ~out_valid | usb_upload_ready;
    payload_ready = (state == S_PAYLOAD) & out_free & (remaining != 16'd0) & ~padding;
    consume       = payload_ready & payload_valid;
  end

  assign usb_upload_data  = out_data;
  assign usb_upload_valid = out_valid;
  assign busy             = (state != S_IDLE);
  assign frame_done       = done_q;
  assign frame_error      = err_q;
  assign state_dbg        = state;

  // Framing FSM with output register, checksum, payload counter and stall watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_q     <= 8'h00;
      len_q     <= 16'h0000;
      remaining <= 16'h0000;
      csum      <= 8'h00;
      stall_cnt <= '0;
      padding   <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            if (frame_len > MAX_LEN_W) begin
              err_q <= 1'b1;
            end else begin
              cmd_q     <= frame_cmd;
              len_q     <= frame_len;
              remaining <= frame_len;
              csum      <= 8'h00;
              stall_cnt <= '0;
              padding   <= 1'b0;
              out_data  <= 8'hAA;
              out_valid <= 1'b1;
              state     <= S_SYNC0;
            end
          end
        end
        S_SYNC0: begin
          if (out_xfer) begin
            out_data <= 8'h55;
            state    <= S_SYNC1;
          end
        end
        S_SYNC1: begin
          if (out_xfer) begin
            out_data <= cmd_q;
            csum     <= cmd_q;
            state    <= S_CMD;
          end
        end
        S_CMD: begin
          if (out_xfer) begin
            out_data <= len_q[15:8];
            csum     <= csum + len_q[15:8];
            state    <= S_LENH;
          end
        end
        S_LENH: begin
          if (out_xfer) begin
            out_data <= len_q[7:0];
            csum     <= csum + len_q[7:0];
            state    <= (len_q == 16'd0) ? S_LENL : S_PAYLOAD;
          end
        end
        S_LENL: begin
          // Only reached for empty payloads: checksum follows LEN_L directly
          if (out_xfer) begin
            out_data <= csum;
            state    <= S_CSUM;
          end
        end
        S_PAYLOAD: begin
          // Register empties on transfer unless a new byte is loaded below
          if (out_xfer) out_valid <= 1'b0;
          if (remaining == 16'd0) begin
            if (out_free) begin
              out_data  <= csum;
              out_valid <= 1'b1;
              state     <= S_CSUM;
            end
          end else if (padding) begin
            if (out_free) begin
              out_data  <= 8'h00;
              out_valid <= 1'b1;
              remaining <= remaining - 16'd1;
            end
          end else if (consume) begin
            out_data  <= payload_data;
            out_valid <= 1'b1;
            csum      <= csum + payload_data;
            remaining <= remaining - 16'd1;
            stall_cnt <= '0;
          end else if (payload_ready) begin
            // Handler has a free slot offered but supplies nothing
            if (stall_cnt == STALL_LAST) begin
              padding   <= 1'b1;
              err_q     <= 1'b1;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + SW'(1);
            end
          end
        end
        S_CSUM: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
